dcache_controller: RTL

- Direct-mapped, write-through, read-allocate data cache between the CPU memory stage and the block-wide data memory.
- Data memory returns a whole 2**BLOCK_SIZE-word block combinationally and writes single words on negedge clk.
- This block holds lines locally, stalls the CPU on read misses, refills a full block in one memory cycle, and forwards every store to memory.
- Provides hit/miss performance counters.

---
 rtl/dcache_pkg.sv | 44 ++++
 rtl/dcache_line_store.sv | 69 ++++++
 rtl/dcache_controller.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg
//   Shared types and address helpers for the direct-mapped data cache.
//   - state_t          : controller FSM states (IDLE, REFILL)
//   - words_per_line   : words in one cache line for a given log2 line size
//   - tag_width        : tag width left over after index and offset bits
//   - get_offset/index/tag : split a word address into its cache fields.
//     The address and result are carried as 64-bit values so a single
//     function serves every width combination; callers cast to the
//     field width they need.
package dcache_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    function automatic int words_per_line(input int block_size);
        return 1 << block_size;
    endfunction

    function automatic int tag_width(input int address_width,
                                     input int set_bits,
                                     input int block_size);
        return address_width - set_bits - block_size;
    endfunction

    function automatic logic [63:0] get_offset(input logic [63:0] addr,
                                               input int          block_size);
        return addr & ((64'd1 << block_size) - 64'd1);
    endfunction

    function automatic logic [63:0] get_index(input logic [63:0] addr,
                                              input int          block_size,
                                              input int          set_bits);
        return (addr >> block_size) & ((64'd1 << set_bits) - 64'd1);
    endfunction

    function automatic logic [63:0] get_tag(input logic [63:0] addr,
                                            input int          block_size,
                                            input int          set_bits);
        return addr >> (block_size + set_bits);
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// dcache_line_store
//   Valid, tag and data arrays of the direct-mapped cache.
//   Ports:
//     clk, rst_n    : clock; async active-low reset clears only the valid bits
//     rd_index      : line selected for the combinational read
//     rd_valid      : valid bit of the selected line
//     rd_tag        : stored tag of the selected line
//     rd_line       : whole selected line, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//     fill_en       : write a complete line (tag, data, set valid)
//     fill_index/fill_tag/fill_line : target and contents of the fill
//     word_en       : overwrite one word of an existing line
//     word_index/word_offset/word_data : target and contents of the word write
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_W      = 23,
    parameter int SET_BITS   = 4,
    parameter int BLOCK_SIZE = 3
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [SET_BITS-1:0]                            rd_index,
    output logic                                           rd_valid,
    output logic [TAG_W-1:0]                               rd_tag,
    output logic [words_per_line(BLOCK_SIZE)*DATA_WIDTH-1:0] rd_line,
    input  logic                                           fill_en,
    input  logic [SET_BITS-1:0]                            fill_index,
    input  logic [TAG_W-1:0]                               fill_tag,
    input  logic [words_per_line(BLOCK_SIZE)*DATA_WIDTH-1:0] fill_line,
    input  logic                                           word_en,
    input  logic [SET_BITS-1:0]                            word_index,
    input  logic [BLOCK_SIZE-1:0]                          word_offset,
    input  logic [DATA_WIDTH-1:0]                          word_data
);

    localparam int NUM_LINES = 1 << SET_BITS;
    localparam int LINE_W    = words_per_line(BLOCK_SIZE) * DATA_WIDTH;

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_array  [NUM_LINES];
    logic [LINE_W-1:0]    data_array [NUM_LINES];

    // NOTE: non-blocking (<=) in every clocked block so all registers update
    // together from pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_index] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays deliberately have no reset; the cleared valid
    // bits make their contents irrelevant, and this keeps them RAM-mappable.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_array[fill_index]  <= fill_tag;
            data_array[fill_index] <= fill_line;
        end else if (word_en) begin
            data_array[word_index][int'(word_offset)*DATA_WIDTH +: DATA_WIDTH] <= word_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_array[rd_index];
    assign rd_line  = data_array[rd_index];

endmodule

// File: rtl/dcache_controller.sv
// dcache_controller
//   Direct-mapped, write-through, read-allocate data cache. Read misses stall
//   the CPU for two cycles while a whole line is loaded from memory in one
//   cycle; every store is forwarded to memory in the cycle it is issued and
//   also updates the cache when the line is resident.
//   Ports:
//     clk, rst_n        : clock; async active-low reset
//     cpu_address       : word address of the access
//     cpu_read_enable   : load request
//     cpu_write_enable  : store request (wins when both enables are high)
//     cpu_write_data    : store data
//     cpu_read_data     : load result, valid on a read with stall low, else 0
//     stall             : CPU holds its request stable while high
//     mem_address       : word address to data memory (always cpu_address)
//     mem_write_data    : store data to data memory
//     mem_write_enable  : store strobe to data memory (committed on negedge)
//     mem_read_data     : whole line from data memory, word i at [i]
//     hit_count         : completed read hits (wraps)
//     miss_count        : read misses (wraps)
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 30,
    parameter int BLOCK_SIZE    = 3,
    parameter int SET_BITS      = 4
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [ADDRESS_WIDTH-1:0]                       cpu_address,
    input  logic                                           cpu_read_enable,
    input  logic                                           cpu_write_enable,
    input  logic [DATA_WIDTH-1:0]                          cpu_write_data,
    output logic [DATA_WIDTH-1:0]                          cpu_read_data,
    output logic                                           stall,
    output logic [ADDRESS_WIDTH-1:0]                       mem_address,
    output logic [DATA_WIDTH-1:0]                          mem_write_data,
    output logic                                           mem_write_enable,
    input  logic [words_per_line(BLOCK_SIZE)*DATA_WIDTH-1:0] mem_read_data,
    output logic [31:0]                                    hit_count,
    output logic [31:0]                                    miss_count
);

    localparam int TAG_W  = tag_width(ADDRESS_WIDTH, SET_BITS, BLOCK_SIZE);
    localparam int LINE_W = words_per_line(BLOCK_SIZE) * DATA_WIDTH;

    state_t state_q, state_d;
    logic   refill_done_q;

    logic [TAG_W-1:0]      addr_tag;
    logic [SET_BITS-1:0]   addr_index;
    logic [BLOCK_SIZE-1:0] addr_offset;

    logic                  line_valid;
    logic [TAG_W-1:0]      line_tag;
    logic [LINE_W-1:0]     line_data;
    logic                  hit;
    logic [DATA_WIDTH-1:0] hit_word;

    logic fill_en;
    logic word_en;
    logic count_hit;
    logic count_miss;

    assign addr_tag    = TAG_W'(get_tag(64'(cpu_address), BLOCK_SIZE, SET_BITS));
    assign addr_index  = SET_BITS'(get_index(64'(cpu_address), BLOCK_SIZE, SET_BITS));
    assign addr_offset = BLOCK_SIZE'(get_offset(64'(cpu_address), BLOCK_SIZE));

    dcache_line_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_W      (TAG_W),
        .SET_BITS   (SET_BITS),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_line_store (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_index    (addr_index),
        .rd_valid    (line_valid),
        .rd_tag      (line_tag),
        .rd_line     (line_data),
        .fill_en     (fill_en),
        .fill_index  (addr_index),
        .fill_tag    (addr_tag),
        .fill_line   (mem_read_data),
        .word_en     (word_en),
        .word_index  (addr_index),
        .word_offset (addr_offset),
        .word_data   (cpu_write_data)
    );

    assign hit      = line_valid && (line_tag == addr_tag);
    assign hit_word = line_data[int'(addr_offset)*DATA_WIDTH +: DATA_WIDTH];

    // Memory always sees the CPU address; only the write strobe is gated.
    assign mem_address    = cpu_address;
    assign mem_write_data = cpu_write_data;

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_d          = state_q;
        stall            = 1'b0;
        cpu_read_data    = '0;
        mem_write_enable = 1'b0;
        fill_en          = 1'b0;
        word_en          = 1'b0;
        count_hit        = 1'b0;
        count_miss       = 1'b0;

        // While reset is asserted the state is forced to IDLE with all lines
        // invalid; without this guard a held read would raise stall.
        if (rst_n) begin
            unique case (state_q)
                IDLE: begin
                    if (cpu_write_enable) begin
                        mem_write_enable = 1'b1;
                        word_en          = hit;
                    end else if (cpu_read_enable) begin
                        if (hit) begin
                            cpu_read_data = hit_word;
                            // The hit that completes a refilled access was
                            // already counted as a miss.
                            count_hit     = !refill_done_q;
                        end else begin
                            stall      = 1'b1;
                            count_miss = 1'b1;
                            state_d    = REFILL;
                        end
                    end
                end
                REFILL: begin
                    stall   = 1'b1;
                    fill_en = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            refill_done_q <= 1'b0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            state_q <= state_d;
            if (fill_en) begin
                refill_done_q <= 1'b1;
            end else if (state_q == IDLE) begin
                refill_done_q <= 1'b0;
            end
            if (count_hit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (count_miss) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end

endmodule
